// File: rtl/cpu_mem_responder_if.sv
// Request/response bundle between the multi-cycle CPU and its memory:
// one instruction-fetch channel and one data load/store channel.
interface cpu_mem_responder_if;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ack;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ack;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ack;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ack;

  modport master (
    output PC, Inst_Req_Valid, Inst_Ack,
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ack,
    input  Inst_Req_Ack, Instruction, Inst_Valid,
    input  Mem_Req_Ack, Read_data, Read_data_Valid
  );

  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ack,
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ack,
    output Inst_Req_Ack, Instruction, Inst_Valid,
    output Mem_Req_Ack, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Word-addressed SRAM serving the CPU fetch and data ports through one shared
// FSM with programmable request/response latency and transaction counters.
module cpu_mem_responder #(
  parameter int    ADDR_W    = 12,
  parameter int    REQ_LAT   = 1,
  parameter int    RSP_LAT   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_mem_responder_if.slave   bus,
  output logic [31:0]          inst_cnt,
  output logic [31:0]          load_cnt,
  output logic [31:0]          store_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ_WAIT = 2'd1;
  localparam logic [1:0] S_RSP_WAIT = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [3:0] REQ_LAT_C = 4'(REQ_LAT);
  localparam logic [3:0] RSP_LAT_C = 4'(RSP_LAT);

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;

  logic              data_req, own_req, own_ack, own_done, mem_we;
  logic [ADDR_W-1:0] req_idx;

  // Owner bit selects which channel's request, address and ack are live.
  assign data_req = bus.MemRead | bus.MemWrite;
  assign own_req  = owner_q ? data_req : bus.Inst_Req_Valid;
  assign req_idx  = owner_q ? bus.Address[ADDR_W+1:2] : bus.PC[ADDR_W+1:2];
  assign own_ack  = (state_q == S_REQ_WAIT) && (cnt_q == 4'd0) && own_req;
  assign own_done = (state_q == S_RESP) && (owner_q ? bus.Read_data_Ack : bus.Inst_Ack);
  assign mem_we   = own_ack && owner_q && wr_q && !rst;

  assign bus.Inst_Req_Ack    = own_ack && !owner_q;
  assign bus.Mem_Req_Ack     = own_ack && owner_q;
  assign bus.Inst_Valid      = (state_q == S_RESP) && !owner_q;
  assign bus.Read_data_Valid = (state_q == S_RESP) && owner_q;
  assign bus.Instruction     = rdata_q;
  assign bus.Read_data       = rdata_q;

  assign inst_cnt  = inst_cnt_q;
  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    rdata_d     = rdata_q;
    inst_cnt_d  = inst_cnt_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          owner_d = 1'b1;
          wr_d    = bus.MemWrite;
          cnt_d   = REQ_LAT_C;
          state_d = S_REQ_WAIT;
        end else if (bus.Inst_Req_Valid) begin
          owner_d = 1'b0;
          wr_d    = 1'b0;
          cnt_d   = REQ_LAT_C;
          state_d = S_REQ_WAIT;
        end
      end
      S_REQ_WAIT: begin
        if (!own_req) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (owner_q && wr_q) begin
          store_cnt_d = store_cnt_q + 32'd1;
          state_d     = S_IDLE;
        end else begin
          rdata_d = mem[req_idx];
          cnt_d   = RSP_LAT_C;
          state_d = S_RSP_WAIT;
        end
      end
      S_RSP_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_RESP;
      end
      default: begin
        // Response held until the owning channel takes it.
        if (own_done) begin
          if (owner_q) load_cnt_d = load_cnt_q + 32'd1;
          else         inst_cnt_d = inst_cnt_q + 32'd1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      rdata_q     <= 32'd0;
      inst_cnt_q  <= 32'd0;
      load_cnt_q  <= 32'd0;
      store_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      rdata_q     <= rdata_d;
      inst_cnt_q  <= inst_cnt_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // Array has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.Write_strb[i]) mem[req_idx][i*8 +: 8] <= bus.Write_data[i*8 +: 8];
      end
    end
  end
endmodule
